z80_io_initiator: RTL and testbench

Z80 I/O bus initiator: turns a valid/ready request (address, write data, direction) into a Z80-style I/O read or write cycle on an 8-bit address bus, a bidirectional data bus and active-low strobes. It returns read data and a one-cycle response pulse. It is the master-side counterpart of the zube Z80 peripheral. It sits in the user project area, driven by firmware-facing logic, and loops back to zube for on-chip self-test.

---
 rtl/z80_io_initiator_pkg.sv | 25 ++
 rtl/z80_io_initiator.sv | 141 ++++++++++++++
 tb/tb_z80_io_initiator.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/z80_io_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : z80_io_initiator_pkg
// Purpose  : Shared Z80 I/O bus definitions (state codes, strobe level, width)
// Revision : 1.0
// ============================================================================
package z80_io_initiator_pkg;

    localparam int c_bus_w = 8;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_setup  = 3'd1;
    localparam logic [2:0] c_st_strobe = 3'd2;
    localparam logic [2:0] c_st_hold   = 3'd3;
    localparam logic [2:0] c_st_resp   = 3'd4;

    localparam logic c_strobe_off = 1'b1;

    // Phase counters count down to zero, so a phase of N cycles loads N-1.
    function automatic logic [3:0] phase_load(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage : z80_io_initiator_pkg
`default_nettype wire

// File: rtl/z80_io_initiator.sv
`default_nettype none
// ============================================================================
// Module   : z80_io_initiator
// Purpose  : Valid/ready request to Z80-style I/O read/write bus cycle master
// Revision : 1.0
// ============================================================================
module z80_io_initiator
    import z80_io_initiator_pkg::*;
#(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 3,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_write_i,
    input  logic [c_bus_w-1:0] req_addr_i,
    input  logic [c_bus_w-1:0] req_wdata_i,
    output logic               rsp_valid_o,
    output logic [c_bus_w-1:0] rsp_rdata_o,
    output logic               rsp_err_o,
    output logic [c_bus_w-1:0] z80_addr_o,
    output logic [c_bus_w-1:0] z80_data_o,
    output logic               z80_data_oe_o,
    input  logic [c_bus_w-1:0] z80_data_i,
    output logic               z80_wr_b_o,
    output logic               z80_rd_b_o,
    input  logic               z80_bus_dir_i
);

    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
        $error("z80_io_initiator: SETUP_CYCLES must be 1..15");
    end
    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
        $error("z80_io_initiator: STROBE_CYCLES must be 1..15");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("z80_io_initiator: HOLD_CYCLES must be 1..15");
    end

    logic [2:0] r_state;
    logic [3:0] r_cnt;
    logic       r_write;
    logic       r_fault;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state       <= c_st_idle;
            r_cnt         <= 4'd0;
            r_write       <= 1'b0;
            r_fault       <= 1'b0;
            req_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            z80_addr_o    <= '0;
            z80_data_o    <= '0;
            z80_data_oe_o <= 1'b0;
            z80_wr_b_o    <= c_strobe_off;
            z80_rd_b_o    <= c_strobe_off;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid_i) begin
                        r_state     <= c_st_setup;
                        r_cnt       <= phase_load(SETUP_CYCLES);
                        r_write     <= req_write_i;
                        r_fault     <= 1'b0;
                        req_ready_o <= 1'b0;
                        rsp_rdata_o <= '0;
                        z80_addr_o  <= req_addr_i;
                        // Data bus keeps its previous value across reads.
                        if (req_write_i) begin
                            z80_data_o    <= req_wdata_i;
                            z80_data_oe_o <= 1'b1;
                        end
                    end
                end
                c_st_setup: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_st_strobe;
                        r_cnt   <= phase_load(STROBE_CYCLES);
                        if (r_write) begin
                            z80_wr_b_o <= ~c_strobe_off;
                        end else begin
                            z80_rd_b_o <= ~c_strobe_off;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_st_strobe: begin
                    // Responder driving the bus while we drive it is contention.
                    if (r_write && z80_bus_dir_i) begin
                        r_fault <= 1'b1;
                    end
                    if (r_cnt == 4'd0) begin
                        r_state    <= c_st_hold;
                        r_cnt      <= phase_load(HOLD_CYCLES);
                        z80_wr_b_o <= c_strobe_off;
                        z80_rd_b_o <= c_strobe_off;
                        if (!r_write) begin
                            rsp_rdata_o <= z80_data_i;
                            r_fault     <= ~z80_bus_dir_i;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_st_hold: begin
                    if (r_cnt == 4'd0) begin
                        r_state       <= c_st_resp;
                        rsp_valid_o   <= 1'b1;
                        rsp_err_o     <= r_fault;
                        z80_data_oe_o <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_st_resp: begin
                    r_state     <= c_st_idle;
                    rsp_valid_o <= 1'b0;
                    rsp_err_o   <= 1'b0;
                    req_ready_o <= 1'b1;
                end
                default: begin
                    r_state       <= c_st_idle;
                    req_ready_o   <= 1'b1;
                    rsp_valid_o   <= 1'b0;
                    z80_data_oe_o <= 1'b0;
                    z80_wr_b_o    <= c_strobe_off;
                    z80_rd_b_o    <= c_strobe_off;
                end
            endcase
        end
    end

endmodule : z80_io_initiator
`default_nettype wire

// File: tb/tb_z80_io_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_z80_io_initiator
// Purpose  : Randomized bench for z80_io_initiator with a phase-timeline model
// Revision : 1.0
// ============================================================================
module tb_z80_io_initiator;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       req_valid;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic [7:0] data_in;
    logic       bus_dir;

    always #5 clk = ~clk;

    logic       ready0, rsp_valid0, rsp_err0, oe0, wr_b0, rd_b0;
    logic [7:0] rdata0, addr0, data0;
    logic       ready1, rsp_valid1, rsp_err1, oe1, wr_b1, rd_b1;
    logic [7:0] rdata1, addr1, data1;
    logic       valid0, valid1;

    assign valid0 = req_valid & ~sel;
    assign valid1 = req_valid & sel;

    z80_io_initiator #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(1)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid_i(valid0), .req_ready_o(ready0), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid0), .rsp_rdata_o(rdata0), .rsp_err_o(rsp_err0),
        .z80_addr_o(addr0), .z80_data_o(data0), .z80_data_oe_o(oe0),
        .z80_data_i(data_in), .z80_wr_b_o(wr_b0), .z80_rd_b_o(rd_b0),
        .z80_bus_dir_i(bus_dir)
    );

    z80_io_initiator #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid_i(valid1), .req_ready_o(ready1), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid1), .rsp_rdata_o(rdata1), .rsp_err_o(rsp_err1),
        .z80_addr_o(addr1), .z80_data_o(data1), .z80_data_oe_o(oe1),
        .z80_data_i(data_in), .z80_wr_b_o(wr_b1), .z80_rd_b_o(rd_b1),
        .z80_bus_dir_i(bus_dir)
    );

    logic       ob_ready, ob_rsp_valid, ob_rsp_err, ob_oe, ob_wr_b, ob_rd_b;
    logic [7:0] ob_rdata, ob_addr, ob_data;

    assign ob_ready     = sel ? ready1     : ready0;
    assign ob_rsp_valid = sel ? rsp_valid1 : rsp_valid0;
    assign ob_rsp_err   = sel ? rsp_err1   : rsp_err0;
    assign ob_oe        = sel ? oe1        : oe0;
    assign ob_wr_b      = sel ? wr_b1      : wr_b0;
    assign ob_rd_b      = sel ? rd_b1      : rd_b0;
    assign ob_rdata     = sel ? rdata1     : rdata0;
    assign ob_addr      = sel ? addr1      : addr0;
    assign ob_data      = sel ? data1      : data0;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] last_wdata [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_reset_state(input string pfx);
        check_eq({pfx, "_ready"}, ob_ready, 1);
        check_eq({pfx, "_rsp_valid"}, ob_rsp_valid, 0);
        check_eq({pfx, "_rdata"}, ob_rdata, 0);
        check_eq({pfx, "_err"}, ob_rsp_err, 0);
        check_eq({pfx, "_addr"}, ob_addr, 0);
        check_eq({pfx, "_data"}, ob_data, 0);
        check_eq({pfx, "_oe"}, ob_oe, 0);
        check_eq({pfx, "_wr_b"}, ob_wr_b, 1);
        check_eq({pfx, "_rd_b"}, ob_rd_b, 1);
    endtask

    // dir_mode: 0 well-behaved responder, 1 dir stuck 0, 2 dir=1 in 2nd strobe cycle, 3 random
    // abort_at: cycle index after accept in which reset is raised (0 = never)
    task automatic run_txn(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                           input int dir_mode, input int abort_at);
        int s, t, h, resp_n;
        bit ok, in_strobe, exp_err;
        logic [7:0] exp_rd;
        s = sel ? 1 : 2;
        t = sel ? 1 : 3;
        h = 1;
        resp_n = s + t + h + 1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ob_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("ready_wait", ok, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        exp_err = 1'b0;
        exp_rd  = 8'h00;
        if (wr) last_wdata[sel] = wdata;
        for (int n = 1; n <= resp_n + 1; n++) begin
            in_strobe = (n > s) && (n <= s + t);
            check_eq("addr", ob_addr, addr);
            check_eq("data_o", ob_data, last_wdata[sel]);
            if (n <= resp_n) begin
                check_eq("ready_busy", ob_ready, 0);
                check_eq("wr_b", ob_wr_b, !(wr && in_strobe));
                check_eq("rd_b", ob_rd_b, !(!wr && in_strobe));
                check_eq("oe", ob_oe, wr && (n <= s + t + h));
                check_eq("rsp_valid", ob_rsp_valid, n == resp_n);
                if (n == resp_n) begin
                    check_eq("rsp_rdata", ob_rdata, exp_rd);
                    check_eq("rsp_err", ob_rsp_err, exp_err);
                end
            end else begin
                check_eq("ready_back", ob_ready, 1);
                check_eq("rsp_valid_end", ob_rsp_valid, 0);
                check_eq("oe_idle", ob_oe, 0);
            end
            data_in = 8'($urandom);
            bus_dir = 1'($urandom);
            if (in_strobe) begin
                case (dir_mode)
                    0: bus_dir = !wr;
                    1: bus_dir = 1'b0;
                    2: bus_dir = (n == s + 2);
                    default: ;
                endcase
                if (wr && bus_dir) exp_err = 1'b1;
                if (!wr && n == s + t) begin
                    exp_rd  = data_in;
                    exp_err = !bus_dir;
                end
            end
            // Busy-time request inputs are garbage that must be ignored.
            if (n <= resp_n) begin
                req_valid = 1'b1;
                req_write = 1'($urandom);
                req_addr  = 8'($urandom);
                req_wdata = 8'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            if (n == abort_at) begin
                req_valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                last_wdata[0] = 8'h00;
                last_wdata[1] = 8'h00;
                check_reset_state("abort");
                repeat (8) begin
                    @(negedge clk);
                    check_eq("abort_no_rsp", ob_rsp_valid, 0);
                end
                return;
            end
            if (n <= resp_n) @(negedge clk);
        end
    endtask

    task automatic random_txn();
        bit wr;
        int mode;
        wr   = 1'($urandom);
        mode = $urandom_range(0, 3);
        if (mode == 2 && !wr) mode = 0;
        run_txn(wr, 8'($urandom), 8'($urandom), mode, 0);
        if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                check_eq("idle_ready", ob_ready, 1);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        data_in   = 8'h00;
        bus_dir   = 1'b0;
        last_wdata[0] = 8'h00;
        last_wdata[1] = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_state("rst0");
        sel = 1'b1;
        check_reset_state("rst1");
        sel = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        run_txn(1'b1, 8'h42, 8'hA5, 0, 0);
        run_txn(1'b0, 8'h10, 8'h00, 0, 0);
        run_txn(1'b0, 8'h20, 8'h00, 1, 0);
        run_txn(1'b1, 8'h30, 8'h5A, 2, 0);
        run_txn(1'b1, 8'h77, 8'hC3, 0, 4);
        repeat (30) random_txn();

        req_valid = 1'b0;
        @(negedge clk);
        sel = 1'b1;
        run_txn(1'b0, 8'hFF, 8'h00, 0, 0);
        run_txn(1'b1, 8'h01, 8'h99, 0, 0);
        repeat (15) random_txn();

        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_z80_io_initiator
`default_nettype wire
